mmc1_cpu_write_sampler: RTL

- Oversampling CPU-bus front end. It sits directly upstream of the MMC1 serial shift/load register logic.
- Samples the asynchronous NES CPU bus (M2, nROMSEL, CPU_RnW, CPU_A14/A13, CPU_D7/D0) on a fast system clock, several times faster than M2.
- Emits one clean single-CLK write strobe per qualified $8000-$FFFF CPU write cycle, carrying the address and data bits the MMC1 register file consumes.
- Enforces the MMC1 rule that a ROM write on the CPU cycle directly after another ROM write is ignored (RMW dummy-write suppression).

---
 rtl/mmc1_cpu_write_sampler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mmc1_cpu_write_sampler.sv
// Oversampling NES CPU-bus front end for the MMC1: synchronizes the bus, qualifies
// M2 high phases, and emits one strobe per accepted $8000-$FFFF write.
module mmc1_cpu_write_sampler #(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_HIGH     = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic M2,
  input  logic nROMSEL,
  input  logic CPU_RnW,
  input  logic CPU_A14,
  input  logic CPU_A13,
  input  logic CPU_D7,
  input  logic CPU_D0,
  output logic WR_STB,
  output logic WR_RST,
  output logic WR_D0,
  output logic WR_A14,
  output logic WR_A13,
  output logic SKIPPED,
  output logic BUS_IDLE
);

  localparam int NB = 7;
  localparam logic [7:0] MIN_HIGH_C = 8'(MIN_HIGH);
  localparam logic [7:0] IDLE_C     = 8'(IDLE_TIMEOUT);
  localparam logic [1:0] BLANK_C    = 2'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_HIGH_QUAL,
    ST_HIGH_VALID
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= IDLE_C) ? IDLE_C : 8'(v + 8'd1);
  endfunction

  logic [NB-1:0] w_bus_in;
  logic [NB-1:0] w_bus_s;
  logic [NB-1:0] r_sync [SYNC_STAGES];
  logic          w_m2_s;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_high_cnt, w_high_cnt_nxt;
  logic       w_fall;
  logic [1:0] r_blank;
  logic       r_armed;

  logic r_sh_nromsel, r_sh_rnw, r_sh_a14, r_sh_a13, r_sh_d7, r_sh_d0;
  logic r_vld_p0;
  logic w_rom_wr, w_accept;

  logic       r_wr_stb, r_wr_rst, r_skipped;
  logic       r_wr_d0, r_wr_a14, r_wr_a13;
  logic       r_prev_wr;
  logic [7:0] r_idle_cnt;
  logic [7:0] w_idle_inc;

  // Input synchronizers: one packed chain keeps every bus field aligned with M2
  assign w_bus_in = {CPU_D0, CPU_D7, CPU_A13, CPU_A14, CPU_RnW, nROMSEL, M2};

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_bus_s = r_sync[SYNC_STAGES-1];
  assign w_m2_s  = w_bus_s[0];

  // After reset the chain holds forced zeros; wait until it carries real pin
  // samples and M2 is seen low, so a half phase cut by reset never qualifies.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_blank <= BLANK_C;
      r_armed <= 1'b0;
    end else begin
      if (r_blank != 2'd0) r_blank <= r_blank - 2'd1;
      if (r_blank == 2'd0 && !w_m2_s) r_armed <= 1'b1;
    end
  end

  // High-phase qualification FSM
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_LOW;
      r_high_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_high_cnt <= w_high_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_high_cnt_nxt = r_high_cnt;
    w_fall         = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (w_m2_s && r_armed) begin
          w_high_cnt_nxt = 8'd1;
          w_state_nxt    = (MIN_HIGH <= 1) ? ST_HIGH_VALID : ST_HIGH_QUAL;
        end
      end
      ST_HIGH_QUAL: begin
        if (!w_m2_s) begin
          w_state_nxt = ST_LOW;
        end else begin
          w_high_cnt_nxt = 8'(r_high_cnt + 8'd1);
          if (w_high_cnt_nxt >= MIN_HIGH_C) w_state_nxt = ST_HIGH_VALID;
        end
      end
      ST_HIGH_VALID: begin
        if (!w_m2_s) begin
          w_state_nxt = ST_LOW;
          w_fall      = 1'b1;
        end
      end
      default: w_state_nxt = ST_LOW;
    endcase
  end

  // Shadow capture: the last high-phase sample survives to the fall event
  always_ff @(posedge CLK) begin
    if (w_m2_s && w_state_nxt != ST_LOW) begin
      r_sh_nromsel <= w_bus_s[1];
      r_sh_rnw     <= w_bus_s[2];
      r_sh_a14     <= w_bus_s[3];
      r_sh_a13     <= w_bus_s[4];
      r_sh_d7      <= w_bus_s[5];
      r_sh_d0      <= w_bus_s[6];
    end
  end

  // p0: registered fall event; shadows stay stable here since M2 is low
  always_ff @(posedge CLK) begin
    if (RST) r_vld_p0 <= 1'b0;
    else     r_vld_p0 <= w_fall;
  end

  assign w_rom_wr   = r_vld_p0 && !r_sh_nromsel && !r_sh_rnw;
  assign w_accept   = w_rom_wr && !r_prev_wr;
  assign w_idle_inc = sat_inc(r_idle_cnt);

  // p1: strobe / skip decision, consecutive-write filter and idle timer
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_stb   <= 1'b0;
      r_wr_rst   <= 1'b0;
      r_skipped  <= 1'b0;
      r_wr_d0    <= 1'b0;
      r_wr_a14   <= 1'b0;
      r_wr_a13   <= 1'b0;
      r_prev_wr  <= 1'b0;
      r_idle_cnt <= IDLE_C;
    end else begin
      r_wr_stb  <= w_accept;
      r_wr_rst  <= w_accept && r_sh_d7;
      r_skipped <= w_rom_wr && r_prev_wr;
      if (w_accept) begin
        r_wr_d0  <= r_sh_d0;
        r_wr_a14 <= r_sh_a14;
        r_wr_a13 <= r_sh_a13;
      end
      if (r_vld_p0) begin
        r_prev_wr  <= w_rom_wr;
        r_idle_cnt <= 8'd0;
      end else begin
        r_idle_cnt <= w_idle_inc;
        if (w_idle_inc == IDLE_C) r_prev_wr <= 1'b0;
      end
    end
  end

  assign WR_STB   = r_wr_stb;
  assign WR_RST   = r_wr_rst;
  assign SKIPPED  = r_skipped;
  assign WR_D0    = r_wr_d0;
  assign WR_A14   = r_wr_a14;
  assign WR_A13   = r_wr_a13;
  assign BUS_IDLE = (r_idle_cnt == IDLE_C);

endmodule
